// File: rtl/reg_bank_32x64_if.sv
// Bus bundle between the write-address decoder tree, the register bank and its readers.
interface reg_bank_32x64_if #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) ();
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             err_clr;
  logic             wr_err;
  logic [7:0]       wr_count;

  modport master (
    output wr_sel, wr_data, rd_addr_a, rd_addr_b, err_clr,
    input  rd_data_a, rd_data_b, wr_err, wr_count
  );

  modport slave (
    input  wr_sel, wr_data, rd_addr_a, rd_addr_b, err_clr,
    output rd_data_a, rd_data_b, wr_err, wr_count
  );
endinterface

// File: rtl/reg_bank_32x64.sv
// 32x64 register bank fed by a one-hot write select; two registered read ports
// with same-edge write bypass, hardwired-zero register and sticky illegal-select flag.
module reg_bank_32x64 #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  reg_bank_32x64_if.slave bus
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             wr_err_q, wr_err_d;
  logic [7:0]       wr_count_q, wr_count_d;

  logic any_sel;
  logic at_most_one;
  logic wr_legal;
  logic wr_illegal;

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  always_comb begin
    any_sel     = |bus.wr_sel;
    at_most_one = ((bus.wr_sel & (bus.wr_sel - NREGS'(1))) == '0);
    wr_legal    = any_sel && at_most_one;
    wr_illegal  = any_sel && !at_most_one;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_legal && bus.wr_sel[i] && (i != ZERO_REG))
        regs_d[i] = bus.wr_data;
    end
  end

  always_comb begin
    rd_data_a_d = regs_q[bus.rd_addr_a];
    if (int'(bus.rd_addr_a) == ZERO_REG)
      rd_data_a_d = '0;
    else if (wr_legal && bus.wr_sel[bus.rd_addr_a])
      rd_data_a_d = bus.wr_data;

    rd_data_b_d = regs_q[bus.rd_addr_b];
    if (int'(bus.rd_addr_b) == ZERO_REG)
      rd_data_b_d = '0;
    else if (wr_legal && bus.wr_sel[bus.rd_addr_b])
      rd_data_b_d = bus.wr_data;
  end

  // A new illegal select outranks a clear arriving on the same edge.
  always_comb begin
    wr_err_d = wr_err_q;
    if (wr_illegal)
      wr_err_d = 1'b1;
    else if (bus.err_clr)
      wr_err_d = 1'b0;

    wr_count_d = wr_count_q + {7'd0, wr_legal};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      wr_err_q    <= 1'b0;
      wr_count_q  <= 8'd0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      wr_err_q    <= wr_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_bank_32x64.sv
// Scoreboard bench for reg_bank_32x64: directed scenarios plus random traffic
// against an array-based reference model.
module tb_reg_bank_32x64;

  typedef struct {
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  reg_bank_32x64_if bus ();

  reg_bank_32x64 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [63:0] m_regs [32];
  int          m_count;
  bit          m_err;

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check64("rd_data_a", bus.rd_data_a, e.rd_a);
        check64("rd_data_b", bus.rd_data_b, e.rd_b);
        check64("wr_err", {63'd0, bus.wr_err}, {63'd0, e.err});
        check64("wr_count", {56'd0, bus.wr_count}, {56'd0, e.cnt});
      end
    end
  end

  function automatic logic [63:0] model_read(int addr, bit legal, int widx, logic [63:0] wdata);
    if (addr == 31) return 64'd0;
    if (legal && widx == addr) return wdata;
    return m_regs[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_count = 0;
    m_err   = 0;
  endtask

  // One clock of stimulus; the expectation is queued just after the edge.
  task automatic drive(logic [31:0] sel, logic [63:0] data, int a, int b, bit clr);
    exp_t e;
    int   ones;
    int   widx;
    bit   legal;
    bus.wr_sel    = sel;
    bus.wr_data   = data;
    bus.rd_addr_a = 5'(a);
    bus.rd_addr_b = 5'(b);
    bus.err_clr   = clr;
    ones  = $countones(sel);
    legal = (ones == 1);
    widx  = -1;
    for (int i = 0; i < 32; i++) if (sel[i]) widx = i;
    e.rd_a = model_read(a, legal, widx, data);
    e.rd_b = model_read(b, legal, widx, data);
    if (legal) begin
      m_count = (m_count + 1) % 256;
      if (widx != 31) m_regs[widx] = data;
    end
    if (ones > 1) m_err = 1;
    else if (clr) m_err = 0;
    e.err = m_err;
    e.cnt = 8'(m_count);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle_read(int a, int b);
    drive(32'd0, 64'd0, a, b, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) idle_read(i, 31 - i);
  endtask

  task automatic check_reset_outputs(string tag);
    check64({tag, "_rd_a"}, bus.rd_data_a, 64'd0);
    check64({tag, "_rd_b"}, bus.rd_data_b, 64'd0);
    check64({tag, "_err"}, {63'd0, bus.wr_err}, 64'd0);
    check64({tag, "_cnt"}, {56'd0, bus.wr_count}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sel;
    logic [63:0] data;
    int          widx;
    int          kind;
    int          a;
    int          b;

    reset_n       = 1'b0;
    bus.wr_sel    = '0;
    bus.wr_data   = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.err_clr   = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("reset_init");
    #9 reset_n = 1'b1;

    read_all();

    drive(32'h1 << 5, 64'hDEAD_BEEF_0000_0005, 0, 1, 1'b0);
    idle_read(5, 5);

    drive(32'h1 << 7, 64'h1234, 7, 7, 1'b0);
    idle_read(7, 7);

    drive(32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 1'b0);
    idle_read(31, 31);

    drive(32'h1, 64'h11, 2, 3, 1'b0);
    drive(32'h2, 64'h22, 0, 1, 1'b0);
    drive(32'h3, 64'hAA, 0, 1, 1'b0);
    idle_read(0, 1);
    drive(32'd0, 64'd0, 0, 1, 1'b1);
    drive(32'h0000_0101, 64'hBB, 0, 8, 1'b1);
    idle_read(0, 8);
    drive(32'd0, 64'd0, 0, 1, 1'b1);

    for (int i = 1; i <= 257; i++) begin
      widx = $urandom_range(0, 31);
      drive(32'h1 << widx, {$urandom, $urandom}, widx, $urandom_range(0, 31), 1'b0);
      if (i == 100) begin
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("reset_mid");
        #1 reset_n = 1'b1;
        read_all();
      end
    end

    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      widx = $urandom_range(0, 31);
      case (kind)
        0, 1:    sel = 32'd0;
        2:       sel = (32'h1 << widx) | (32'h1 << ((widx + $urandom_range(1, 31)) % 32));
        3:       sel = $urandom;
        default: sel = 32'h1 << widx;
      endcase
      data = {$urandom, $urandom};
      a = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 31);
      b = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 31);
      drive(sel, data, a, b, ($urandom_range(0, 7) == 0));
    end

    read_all();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
